// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state encoding and the default launch-acknowledge timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_e;

  localparam int ACK_TIMEOUT_DEFAULT = 4;

endpackage

// File: rtl/uart_rr_select.sv
// Combinational round-robin selector: the first set request at or after (last_i + 1), wrapping.
module uart_rr_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       valid_o
);

  localparam int IW = $clog2(NUM_REQ);

  int            idx;
  logic [IW-1:0] idx_w;
  logic          found;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    found    = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_i) + i) % NUM_REQ;
      idx_w = idx[IW-1:0];
      if (!found && req_i[idx_w]) begin
        winner_o = idx_w;
        found    = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one UART transmitter,
// with a launch-acknowledge timeout on the transmitter's busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_parallel_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    active_id,
  output logic                          arb_idle,
  output logic                          launch_error
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  // The error is flagged on the edge where the count would reach ACK_TIMEOUT-1, so the
  // pulse lands ACK_TIMEOUT cycles after the LAUNCH cycle (ACK_TIMEOUT must be >= 2).
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 2);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic [IW-1:0]         winner;
  logic                  winner_valid;

  uart_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .valid_o  (winner_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    grant_d = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (winner_valid && !tx_busy) begin
          state_d         = ST_LAUNCH;
          last_d          = winner;
          id_d            = winner;
          data_d          = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
          grant_d[winner] = 1'b1;
          valid_d         = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      id_q    <= '0;
      data_q  <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign grant            = grant_q;
  assign tx_data_valid    = valid_q;
  assign tx_parallel_data = data_q;
  assign active_id        = id_q;
  assign launch_error     = err_q;
  assign arb_idle         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (defaults: 8-bit data, 4 requesters, timeout 4).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        tx_data_valid;
  logic [7:0]  tx_parallel_data;
  logic        tx_busy;
  logic [1:0]  active_id;
  logic        arb_idle;
  logic        launch_error;

  int vectors     = 0;
  int miscompares = 0;
  int extra_grant;
  int extra_valid;

  uart_tx_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_data         (req_data),
    .grant            (grant),
    .tx_data_valid    (tx_data_valid),
    .tx_parallel_data (tx_parallel_data),
    .tx_busy          (tx_busy),
    .active_id        (active_id),
    .arb_idle         (arb_idle),
    .launch_error     (launch_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " arb_idle"}, 32'(arb_idle), 32'h1);
    check({tag, " grant"}, 32'(grant), 32'h0);
    check({tag, " tx_data_valid"}, 32'(tx_data_valid), 32'h0);
    check({tag, " tx_parallel_data"}, 32'(tx_parallel_data), 32'h0);
    check({tag, " active_id"}, 32'(active_id), 32'h0);
    check({tag, " launch_error"}, 32'(launch_error), 32'h0);
  endtask

  // Starts in IDLE with requests applied; grants, acknowledges, and returns to IDLE.
  task automatic do_transfer(input int id, input logic [7:0] byte_v, input logic [3:0] req_after);
    tick();
    check($sformatf("grant to %0d", id), 32'(grant), 32'(1) << id);
    check($sformatf("launch valid %0d", id), 32'(tx_data_valid), 32'h1);
    check($sformatf("launch data %0d", id), 32'(tx_parallel_data), 32'(byte_v));
    check($sformatf("launch id %0d", id), 32'(active_id), 32'(id));
    check($sformatf("launch not idle %0d", id), 32'(arb_idle), 32'h0);
    req = req_after;
    tick();
    check($sformatf("grant clears %0d", id), 32'(grant), 32'h0);
    check($sformatf("valid clears %0d", id), 32'(tx_data_valid), 32'h0);
    tx_busy = 1'b1;
    tick();
    check($sformatf("busy wait %0d", id), 32'(arb_idle), 32'h0);
    check($sformatf("id held %0d", id), 32'(active_id), 32'(id));
    tx_busy = 1'b0;
    tick();
    check($sformatf("idle after busy %0d", id), 32'(arb_idle), 32'h1);
    check($sformatf("no error %0d", id), 32'(launch_error), 32'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    tx_busy  = 1'b0;
    req_data = 32'h332211A5;
    tick();
    tick();
    check_reset_values("reset");

    // Fairness with all four requesting continuously
    reset = 1'b0;
    req   = 4'b1111;
    do_transfer(0, 8'hA5, 4'b1111);
    do_transfer(1, 8'h11, 4'b1111);
    do_transfer(2, 8'h22, 4'b1111);
    do_transfer(3, 8'h33, 4'b1111);
    do_transfer(0, 8'hA5, 4'b0000);

    // Wrap: make 3 the last winner, then 0 and 3 both request
    req = 4'b1000;
    do_transfer(3, 8'h33, 4'b0000);
    req = 4'b1001;
    do_transfer(0, 8'hA5, 4'b1000);
    do_transfer(3, 8'h33, 4'b0000);

    // Single request with a 10-cycle busy period
    req = 4'b0001;
    tick();
    check("single grant", 32'(grant), 32'h1);
    check("single valid", 32'(tx_data_valid), 32'h1);
    check("single data", 32'(tx_parallel_data), 32'hA5);
    req = 4'b0000;
    tick();
    check("single grant clears", 32'(grant), 32'h0);
    check("single valid clears", 32'(tx_data_valid), 32'h0);
    tx_busy     = 1'b1;
    extra_grant = 0;
    extra_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (grant != 4'b0000) extra_grant++;
      if (tx_data_valid) extra_valid++;
    end
    check("single extra grants", 32'(extra_grant), 32'h0);
    check("single extra valids", 32'(extra_valid), 32'h0);
    check("single still busy", 32'(arb_idle), 32'h0);
    check("single data held", 32'(tx_parallel_data), 32'hA5);
    tx_busy = 1'b0;
    tick();
    check("single idle after busy", 32'(arb_idle), 32'h1);

    // Timeout: requester 1 launched, busy never rises
    req = 4'b0010;
    tick();
    check("timeout grant", 32'(grant), 32'h2);
    check("timeout data", 32'(tx_parallel_data), 32'h11);
    req = 4'b0000;
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("no early error %0d", i), 32'(launch_error), 32'h0);
    end
    tick();
    check("timeout error pulse", 32'(launch_error), 32'h1);
    check("timeout back to idle", 32'(arb_idle), 32'h1);
    check("timeout no grant", 32'(grant), 32'h0);
    req = 4'b0111;
    tick();
    check("error one cycle", 32'(launch_error), 32'h0);
    check("post-timeout grant", 32'(grant), 32'h4);
    check("post-timeout id", 32'(active_id), 32'h2);
    req = 4'b0100;
    tick();
    tx_busy = 1'b1;
    tick();
    check("in wait_done", 32'(arb_idle), 32'h0);

    // Asynchronous reset in WAIT_DONE, held two cycles
    reset = 1'b1;
    #1;
    check_reset_values("async reset");
    tick();
    tick();
    check_reset_values("held reset");
    reset   = 1'b0;
    tx_busy = 1'b0;
    req     = 4'b0101;
    do_transfer(0, 8'hA5, 4'b0000);

    // Busy-blocked arbitration in IDLE
    tx_busy = 1'b1;
    req     = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("blocked grant %0d", i), 32'(grant), 32'h0);
      check($sformatf("blocked idle %0d", i), 32'(arb_idle), 32'h1);
    end
    tx_busy = 1'b0;
    do_transfer(0, 8'hA5, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
